id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Sequences the decode stage of the 5-stage RISC-V pipeline.
- Generates the ID-stage forwarding selects (forward_data_reg1/2), the control-bubble select (ctrl_sel), PC and IF/ID write enables, PC redirect and flush.
- Resolves load-use and writeback-collision hazards by stalling, and resolves branch/jump redirects in ID with a one-cycle squash, under a small FSM.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- IF_ID_rs1  in  REG_AW  decode rs1
- IF_ID_rs2  in  REG_AW  decode rs2
- id_use_rs1  in  1  decoded instruction reads rs1
- id_use_rs2  in  1  decoded instruction reads rs2
- id_is_branch  in  1  decoded instruction is BEQ
- id_is_jump  in  1  decoded instruction is JAL
- br_eq  in  1  ID compare result, already using the forwarded operands
- ID_EX_rd  in  REG_AW  destination of the instruction in EX
- ID_EX_reg_write  in  1  EX instruction writes the register file
- ID_EX_mem_read  in  1  EX instruction is a load
- EX_MEM_rd  in  REG_AW  destination of the instruction in MEM
- EX_MEM_reg_write  in  1  MEM instruction writes the register file
- MEM_WB_rd  in  REG_AW  destination of the instruction in WB
- MEM_WB_reg_write  in  1  WB instruction writes the register file
- forward_data_reg1  out  2  00 = regfile, 01 = alu_out, 10 = EX/MEM result
- forward_data_reg2  out  2  same encoding as forward_data_reg1
- ctrl_sel  out  1  1 = pass decoded controls into ID/EX, 0 = bubble
- pc_write  out  1  PC register update enable
- if_id_write  out  1  IF/ID register update enable
- pc_sel  out  1  1 = next PC is pc_branch
- if_id_flush  out  1  IF/ID loads a NOP on the next edge
- stall  out  1  registered; 1 while the FSM is in STALL

Behaviour:
- Match definitions (per source s = rs1 or rs2, only when id_use_s = 1 and IF_ID_s != 0):
  - mEX = ID_EX_reg_write and ID_EX_rd == s
  - mMEM = EX_MEM_reg_write and EX_MEM_rd == s
  - mWB = MEM_WB_reg_write and MEM_WB_rd == s
- Forward select, priority youngest first:
  - mEX and not ID_EX_mem_read -> 01
  - else mMEM -> 10
  - else 00
- Hazard conditions:
  - ld_haz = any used source with mEX and ID_EX_mem_read.
  - wb_haz = any used source with mWB, no mEX and no mMEM. Regfile write-then-read within the same cycle returns the stale value, so this case must stall.
  - haz = ld_haz or wb_haz.
- taken = not haz and (id_is_jump or (id_is_branch and br_eq)).
- FSM states: RUN, STALL, FLUSH. Registered; reset state RUN.
- RUN:
  - haz -> pc_write=0, if_id_write=0, ctrl_sel=0, pc_sel=0; next STALL.
  - taken -> pc_write=1, pc_sel=1, if_id_write=1, if_id_flush=1, ctrl_sel=1; next FLUSH.
  - otherwise -> pc_write=1, if_id_write=1, ctrl_sel=1, pc_sel=0, if_id_flush=0; stay in RUN.
- STALL: same decode as RUN; hazards re-evaluated every cycle. Exits to RUN (or FLUSH if taken) once haz clears. A load followed by a WB collision can chain stalls.
- FLUSH:
  - ctrl_sel=0 (squashes the wrong-path instruction in ID); pc_write=1, if_id_write=1, pc_sel=0, if_id_flush=0.
  - Hazards and branch flags are ignored; forward selects forced to 00.
  - Next RUN.
- Precedence: haz beats taken. A branch waiting on a load is never redirected with stale br_eq.
- stall is registered: 1 in the cycle after entry to STALL, for as long as the FSM stays in STALL.
- Reset (reset_n=0 at a clk edge, including mid-stall or mid-flush):
  - FSM -> RUN, stall=0.
  - While reset_n=0, outputs are forced: pc_write=0, if_id_write=0, ctrl_sel=0, pc_sel=0, if_id_flush=0, forward selects 00.
- Register x0 never forwards and never causes a hazard.
- Latency: forward selects and redirects are combinational in the same cycle; stall penalty is 1 cycle per hazard; taken-branch penalty is 1 cycle.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined: adds outputs perf_stall_cnt, perf_flush_cnt and perf_instr_cnt (each CNT_W wide).
  - Incremented on cycles in STALL state, FLUSH state, and RUN with ctrl_sel=1, respectively.
  - Saturate at all-ones; cleared by reset.
- When not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ADD x5 in EX (ID_EX_reg_write=1, mem_read=0, rd=5), ID reads rs1=5 -> forward_data_reg1=01, ctrl_sel=1, pc_write=1, no stall.
- LW x6 in EX (mem_read=1, rd=6), ID BEQ with rs2=6 -> 1 stall cycle (pc_write=0, ctrl_sel=0); next cycle EX_MEM_rd=6 -> forward_data_reg2=10, state back to RUN.
- MEM_WB_rd=7 with reg_write=1, ID rs1=7, no EX/MEM match -> 1 stall cycle; next cycle forward 00, proceeds.
- BEQ with br_eq=1, no hazard -> pc_sel=1, if_id_flush=1; following cycle ctrl_sel=0; third cycle RUN with ctrl_sel=1.
- ID_EX_rd=0 with mem_read=1, ID rs1=0 -> no stall, forward 00.
- reset_n driven low while in STALL -> next edge state RUN, all outputs 0 during reset; with HAZ_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller for the 5-stage RISC-V pipeline.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module id_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] IF_ID_rs1,
  input  logic [REG_AW-1:0] IF_ID_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_branch,
  input  logic              id_is_jump,
  input  logic              br_eq,
  input  logic [REG_AW-1:0] ID_EX_rd,
  input  logic              ID_EX_reg_write,
  input  logic              ID_EX_mem_read,
  input  logic [REG_AW-1:0] EX_MEM_rd,
  input  logic              EX_MEM_reg_write,
  input  logic [REG_AW-1:0] MEM_WB_rd,
  input  logic              MEM_WB_reg_write,
  output logic [1:0]        forward_data_reg1,
  output logic [1:0]        forward_data_reg2,
  output logic              ctrl_sel,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              pc_sel,
  output logic              if_id_flush,
  output logic              stall
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt,
  output logic [CNT_W-1:0]  perf_instr_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;
  logic   stall_r;

  logic m_ex1_s, m_mem1_s, m_wb1_s;
  logic m_ex2_s, m_mem2_s, m_wb2_s;
  logic [1:0] fwd1_s, fwd2_s;
  logic ld_haz_s, wb_haz_s, haz_s, taken_s;

  // x0 is hard-wired, so it never matches a producer.
  function automatic logic src_match(
    input logic              use_src,
    input logic [REG_AW-1:0] src,
    input logic              wr,
    input logic [REG_AW-1:0] rd
  );
    return use_src && (src != {REG_AW{1'b0}}) && wr && (rd == src);
  endfunction

  // A load in EX has no result yet; fall through to the MEM producer.
  function automatic logic [1:0] fwd_sel(
    input logic m_ex,
    input logic m_mem,
    input logic ex_is_load
  );
    logic [1:0] sel;
    if (m_ex && !ex_is_load) begin
      sel = 2'b01;
    end else if (m_mem) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  assign m_ex1_s  = src_match(id_use_rs1, IF_ID_rs1, ID_EX_reg_write,  ID_EX_rd);
  assign m_mem1_s = src_match(id_use_rs1, IF_ID_rs1, EX_MEM_reg_write, EX_MEM_rd);
  assign m_wb1_s  = src_match(id_use_rs1, IF_ID_rs1, MEM_WB_reg_write, MEM_WB_rd);
  assign m_ex2_s  = src_match(id_use_rs2, IF_ID_rs2, ID_EX_reg_write,  ID_EX_rd);
  assign m_mem2_s = src_match(id_use_rs2, IF_ID_rs2, EX_MEM_reg_write, EX_MEM_rd);
  assign m_wb2_s  = src_match(id_use_rs2, IF_ID_rs2, MEM_WB_reg_write, MEM_WB_rd);

  assign fwd1_s = fwd_sel(m_ex1_s, m_mem1_s, ID_EX_mem_read);
  assign fwd2_s = fwd_sel(m_ex2_s, m_mem2_s, ID_EX_mem_read);

  // Hazard detection; a WB-only match stalls because the regfile read is stale.
  always_comb begin
    ld_haz_s = ID_EX_mem_read && (m_ex1_s || m_ex2_s);
    wb_haz_s = (m_wb1_s && !m_ex1_s && !m_mem1_s) ||
               (m_wb2_s && !m_ex2_s && !m_mem2_s);
    haz_s    = ld_haz_s || wb_haz_s;
    taken_s  = !haz_s && (id_is_jump || (id_is_branch && br_eq));
  end

  // Output decode and next-state selection.
  always_comb begin
    forward_data_reg1 = 2'b00;
    forward_data_reg2 = 2'b00;
    ctrl_sel          = 1'b0;
    pc_write          = 1'b0;
    if_id_write       = 1'b0;
    pc_sel            = 1'b0;
    if_id_flush       = 1'b0;
    state_next_s      = RUN;
    if (!reset_n) begin
      state_next_s = RUN;
    end else begin
      case (state_r)
        RUN, STALL: begin
          forward_data_reg1 = fwd1_s;
          forward_data_reg2 = fwd2_s;
          if (haz_s) begin
            state_next_s = STALL;
          end else if (taken_s) begin
            ctrl_sel     = 1'b1;
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            pc_sel       = 1'b1;
            if_id_flush  = 1'b1;
            state_next_s = FLUSH;
          end else begin
            ctrl_sel     = 1'b1;
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            state_next_s = RUN;
          end
        end
        FLUSH: begin
          // Wrong-path instruction in ID becomes a bubble.
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          state_next_s = RUN;
        end
        default: begin
          state_next_s = RUN;
        end
      endcase
    end
  end

  // FSM state and registered stall flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= RUN;
      stall_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      stall_r <= (state_next_s == STALL);
    end
  end

  assign stall = stall_r;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r, instr_cnt_r;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
      instr_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (state_r == STALL) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (state_r == FLUSH) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
      if ((state_r == RUN) && ctrl_sel) begin
        instr_cnt_r <= sat_inc(instr_cnt_r);
      end else begin
        instr_cnt_r <= instr_cnt_r;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_r;
  assign perf_flush_cnt = flush_cnt_r;
  assign perf_instr_cnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios plus random
// stimulus against a stage-oriented reference model.
module tb_id_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [REG_AW-1:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
  logic id_use_rs1, id_use_rs2, id_is_branch, id_is_jump, br_eq;
  logic ID_EX_reg_write, ID_EX_mem_read, EX_MEM_reg_write, MEM_WB_reg_write;
  logic [1:0] forward_data_reg1, forward_data_reg2;
  logic ctrl_sel, pc_write, if_id_write, pc_sel, if_id_flush, stall;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt, perf_instr_cnt;
`endif

  id_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_branch(id_is_branch), .id_is_jump(id_is_jump), .br_eq(br_eq),
    .ID_EX_rd(ID_EX_rd), .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_reg_write(EX_MEM_reg_write),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_reg_write(MEM_WB_reg_write),
    .forward_data_reg1(forward_data_reg1), .forward_data_reg2(forward_data_reg2),
    .ctrl_sel(ctrl_sel), .pc_write(pc_write), .if_id_write(if_id_write),
    .pc_sel(pc_sel), .if_id_flush(if_id_flush), .stall(stall)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_instr_cnt(perf_instr_cnt)
`endif
  );

  // {fwd1, fwd2, ctrl_sel, pc_write, if_id_write, pc_sel, if_id_flush, stall}
  logic [9:0] obs;
  assign obs = {forward_data_reg1, forward_data_reg2, ctrl_sel, pc_write,
                if_id_write, pc_sel, if_id_flush, stall};

  int total = 0;
  int bad   = 0;

  // Reference model state: is the pipeline holding, or squashing?
  bit m_holding  = 1'b0;
  bit m_squashing = 1'b0;
  longint m_cnt_stall = 0, m_cnt_flush = 0, m_cnt_instr = 0;

  // Per-source view: find the youngest stage writing the register.
  function automatic void src_info(input logic use_s, input logic [REG_AW-1:0] s,
                                   output logic [1:0] fwd, output logic ld, output logic wb);
    logic [REG_AW-1:0] rd [3];
    logic wr [3];
    int youngest;
    rd = '{ID_EX_rd, EX_MEM_rd, MEM_WB_rd};
    wr = '{ID_EX_reg_write, EX_MEM_reg_write, MEM_WB_reg_write};
    fwd = 2'b00; ld = 1'b0; wb = 1'b0; youngest = -1;
    if (use_s && s != 0) begin
      for (int k = 2; k >= 0; k--)
        if (wr[k] && rd[k] == s) youngest = k;
      // Nearest stage that actually has a value ready (a load in EX does not).
      for (int k = 1; k >= 0; k--)
        if (wr[k] && rd[k] == s && !(k == 0 && ID_EX_mem_read)) fwd = (k == 0) ? 2'b01 : 2'b10;
      ld = (youngest == 0) && ID_EX_mem_read;
      wb = (youngest == 2);
    end
  endfunction

  function automatic logic m_hazard();
    logic [1:0] f; logic l1, w1, l2, w2;
    src_info(id_use_rs1, IF_ID_rs1, f, l1, w1);
    src_info(id_use_rs2, IF_ID_rs2, f, l2, w2);
    return l1 | w1 | l2 | w2;
  endfunction

  function automatic logic [9:0] m_expect();
    logic [1:0] f1, f2; logic l, w, haz, taken;
    src_info(id_use_rs1, IF_ID_rs1, f1, l, w);
    src_info(id_use_rs2, IF_ID_rs2, f2, l, w);
    haz   = m_hazard();
    taken = !haz && (id_is_jump || (id_is_branch && br_eq));
    if (!reset_n)         return {9'b0, m_holding};
    else if (m_squashing) return {4'b0000, 5'b01100, m_holding};
    else if (haz)         return {f1, f2, 5'b00000, m_holding};
    else if (taken)       return {f1, f2, 5'b11111, m_holding};
    else                  return {f1, f2, 5'b11100, m_holding};
  endfunction

  // Advance one clock and move the model forward with the same inputs.
  task automatic tick();
    logic haz, taken, run_issue;
    haz       = m_hazard();
    taken     = !haz && (id_is_jump || (id_is_branch && br_eq));
    run_issue = !m_holding && !m_squashing && !haz;
    @(posedge clk);
    if (!reset_n) begin
      m_holding = 0; m_squashing = 0;
      m_cnt_stall = 0; m_cnt_flush = 0; m_cnt_instr = 0;
    end else begin
      if (m_holding) m_cnt_stall++;
      if (m_squashing) m_cnt_flush++;
      if (run_issue) m_cnt_instr++;
      if (m_squashing) begin
        m_squashing = 0; m_holding = 0;
      end else begin
        m_holding   = haz;
        m_squashing = taken;
      end
    end
    #1;
  endtask

  task automatic idle();
    IF_ID_rs1 = '0; IF_ID_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_is_branch = 0; id_is_jump = 0; br_eq = 0;
    ID_EX_rd = '0; ID_EX_reg_write = 0; ID_EX_mem_read = 0;
    EX_MEM_rd = '0; EX_MEM_reg_write = 0; MEM_WB_rd = '0; MEM_WB_reg_write = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; idle();
    tick(); tick();
    #4;
    total++;
    if (obs !== 10'b00_00_0_0_0_0_0_0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", obs, 10'b0);
    end
`ifdef HAZ_PERF_CNT_EN
    total++;
    if ({perf_stall_cnt, perf_flush_cnt, perf_instr_cnt} !== {(3*CNT_W){1'b0}}) begin
      bad++; $display("FAIL reset_counters: got %0d %0d %0d want 0 0 0",
                      perf_stall_cnt, perf_flush_cnt, perf_instr_cnt);
    end
`endif
    tick();
    reset_n = 1;
    #4;
    total++;
    if (obs !== 10'b00_00_1_1_1_0_0_0) begin
      bad++; $display("FAIL reset_release: got %b want %b", obs, 10'b00_00_1_1_1_0_0_0);
    end
    tick();
  endtask

  task automatic test_fwd_ex();
    idle();
    ID_EX_rd = 5'd5; ID_EX_reg_write = 1; IF_ID_rs1 = 5'd5; id_use_rs1 = 1;
    #4;
    total++;
    if (obs !== 10'b01_00_1_1_1_0_0_0) begin
      bad++; $display("FAIL fwd_ex: got %b want %b", obs, 10'b01_00_1_1_1_0_0_0);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    ID_EX_rd = 5'd6; ID_EX_reg_write = 1; ID_EX_mem_read = 1;
    id_is_branch = 1; br_eq = 1; IF_ID_rs2 = 5'd6; id_use_rs2 = 1;
    IF_ID_rs1 = 5'd1; id_use_rs1 = 1;
    #4;
    total++;
    if (obs !== 10'b00_00_0_0_0_0_0_0) begin
      bad++; $display("FAIL load_use_stall: got %b want %b", obs, 10'b0);
    end
    tick();
    ID_EX_rd = '0; ID_EX_reg_write = 0; ID_EX_mem_read = 0;
    EX_MEM_rd = 5'd6; EX_MEM_reg_write = 1; br_eq = 0;
    #4;
    total++;
    if (obs !== 10'b00_10_1_1_1_0_0_1) begin
      bad++; $display("FAIL load_use_resume: got %b want %b", obs, 10'b00_10_1_1_1_0_0_1);
    end
    tick();
    idle();
    #4;
    total++;
    if (obs !== 10'b00_00_1_1_1_0_0_0) begin
      bad++; $display("FAIL load_use_after: got %b want %b", obs, 10'b00_00_1_1_1_0_0_0);
    end
    tick();
  endtask

  task automatic test_wb_haz();
    idle();
    MEM_WB_rd = 5'd7; MEM_WB_reg_write = 1; IF_ID_rs1 = 5'd7; id_use_rs1 = 1;
    #4;
    total++;
    if (obs !== 10'b00_00_0_0_0_0_0_0) begin
      bad++; $display("FAIL wb_haz_stall: got %b want %b", obs, 10'b0);
    end
    tick();
    MEM_WB_rd = '0; MEM_WB_reg_write = 0;
    #4;
    total++;
    if (obs !== 10'b00_00_1_1_1_0_0_1) begin
      bad++; $display("FAIL wb_haz_resume: got %b want %b", obs, 10'b00_00_1_1_1_0_0_1);
    end
    tick();
  endtask

  task automatic test_branch();
    idle();
    id_is_branch = 1; br_eq = 1;
    #4;
    total++;
    if (obs !== 10'b00_00_1_1_1_1_1_0) begin
      bad++; $display("FAIL branch_taken: got %b want %b", obs, 10'b00_00_1_1_1_1_1_0);
    end
    tick();
    // Squash cycle ignores a load-use hazard and a jump in ID.
    id_is_branch = 0; id_is_jump = 1;
    ID_EX_rd = 5'd3; ID_EX_reg_write = 1; ID_EX_mem_read = 1; IF_ID_rs1 = 5'd3; id_use_rs1 = 1;
    #4;
    total++;
    if (obs !== 10'b00_00_0_1_1_0_0_0) begin
      bad++; $display("FAIL branch_squash: got %b want %b", obs, 10'b00_00_0_1_1_0_0_0);
    end
    tick();
    idle();
    #4;
    total++;
    if (obs !== 10'b00_00_1_1_1_0_0_0) begin
      bad++; $display("FAIL branch_after: got %b want %b", obs, 10'b00_00_1_1_1_0_0_0);
    end
    tick();
    id_is_jump = 1;
    #4;
    total++;
    if (obs !== 10'b00_00_1_1_1_1_1_0) begin
      bad++; $display("FAIL jump_taken: got %b want %b", obs, 10'b00_00_1_1_1_1_1_0);
    end
    tick();
    idle(); tick();
  endtask

  task automatic test_x0();
    idle();
    ID_EX_rd = '0; ID_EX_reg_write = 1; ID_EX_mem_read = 1;
    MEM_WB_rd = '0; MEM_WB_reg_write = 1;
    IF_ID_rs1 = '0; id_use_rs1 = 1; IF_ID_rs2 = '0; id_use_rs2 = 1;
    #4;
    total++;
    if (obs !== 10'b00_00_1_1_1_0_0_0) begin
      bad++; $display("FAIL x0_no_hazard: got %b want %b", obs, 10'b00_00_1_1_1_0_0_0);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    idle();
    ID_EX_rd = 5'd9; ID_EX_reg_write = 1; ID_EX_mem_read = 1; IF_ID_rs1 = 5'd9; id_use_rs1 = 1;
    tick();
    reset_n = 0;
    #4;
    total++;
    if (obs !== 10'b00_00_0_0_0_0_0_1) begin
      bad++; $display("FAIL reset_in_stall: got %b want %b", obs, 10'b00_00_0_0_0_0_0_1);
    end
    tick();
    #4;
    total++;
    if (obs !== 10'b00_00_0_0_0_0_0_0) begin
      bad++; $display("FAIL reset_after_stall: got %b want %b", obs, 10'b0);
    end
`ifdef HAZ_PERF_CNT_EN
    total++;
    if ({perf_stall_cnt, perf_flush_cnt, perf_instr_cnt} !== {(3*CNT_W){1'b0}}) begin
      bad++; $display("FAIL reset_stall_counters: got %0d %0d %0d want 0 0 0",
                      perf_stall_cnt, perf_flush_cnt, perf_instr_cnt);
    end
`endif
    tick();
    reset_n = 1; idle(); tick();
  endtask

  task automatic test_random();
    logic [9:0] exp;
    for (int n = 0; n < 400; n++) begin
      reset_n          = ($urandom_range(0, 31) != 0);
      IF_ID_rs1        = REG_AW'($urandom_range(0, 3));
      IF_ID_rs2        = REG_AW'($urandom_range(0, 3));
      id_use_rs1       = 1'($urandom);
      id_use_rs2       = 1'($urandom);
      id_is_branch     = 1'($urandom);
      id_is_jump       = ($urandom_range(0, 3) == 0);
      br_eq            = 1'($urandom);
      ID_EX_rd         = REG_AW'($urandom_range(0, 3));
      ID_EX_reg_write  = 1'($urandom);
      ID_EX_mem_read   = 1'($urandom);
      EX_MEM_rd        = REG_AW'($urandom_range(0, 3));
      EX_MEM_reg_write = 1'($urandom);
      MEM_WB_rd        = REG_AW'($urandom_range(0, 3));
      MEM_WB_reg_write = 1'($urandom);
      #4;
      exp = m_expect();
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL random_cycle_%0d: got %b want %b", n, obs, exp);
      end
      tick();
`ifdef HAZ_PERF_CNT_EN
      total++;
      if ({64'(perf_stall_cnt), 64'(perf_flush_cnt), 64'(perf_instr_cnt)} !==
          {m_cnt_stall, m_cnt_flush, m_cnt_instr}) begin
        bad++; $display("FAIL random_counters_%0d: got %0d %0d %0d want %0d %0d %0d", n,
                        perf_stall_cnt, perf_flush_cnt, perf_instr_cnt,
                        m_cnt_stall, m_cnt_flush, m_cnt_instr);
      end
`endif
    end
    reset_n = 1; idle(); tick();
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_wb_haz();
    test_branch();
    test_x0();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
